// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if
//   Bundles the two requester channels and the ROM port of rom_arbiter.
//   slave  : arbiter side (takes requests, drives responses and the ROM port).
//   master : environment side (requesters plus the ROM itself).
//   Port 0 = instruction fetch, port 1 = load/store.
//   pN_req_*  : valid/ready request channel, 30-bit word address (addr[31:2]).
//   pN_resp_* : valid/ready response channel, 32-bit data plus range error.
//   rom_re/rom_addr : ROM read strobe and word address; rom_rd : ROM data
//   (registered by the ROM on the falling clock edge).
interface rom_arbiter_if;
  logic        p0_req_valid;
  logic        p0_req_ready;
  logic [29:0] p0_req_addr;
  logic        p0_resp_valid;
  logic        p0_resp_ready;
  logic [31:0] p0_resp_data;
  logic        p0_resp_err;

  logic        p1_req_valid;
  logic        p1_req_ready;
  logic [29:0] p1_req_addr;
  logic        p1_resp_valid;
  logic        p1_resp_ready;
  logic [31:0] p1_resp_data;
  logic        p1_resp_err;

  logic        rom_re;
  logic [29:0] rom_addr;
  logic [31:0] rom_rd;

  modport slave (
    input  p0_req_valid, p0_req_addr, p0_resp_ready,
    input  p1_req_valid, p1_req_addr, p1_resp_ready,
    input  rom_rd,
    output p0_req_ready, p0_resp_valid, p0_resp_data, p0_resp_err,
    output p1_req_ready, p1_resp_valid, p1_resp_data, p1_resp_err,
    output rom_re, rom_addr
  );

  modport master (
    output p0_req_valid, p0_req_addr, p0_resp_ready,
    output p1_req_valid, p1_req_addr, p1_resp_ready,
    output rom_rd,
    input  p0_req_ready, p0_resp_valid, p0_resp_data, p0_resp_err,
    input  p1_req_ready, p1_resp_valid, p1_resp_data, p1_resp_err,
    input  rom_re, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one single-read-port ROM between the fetch requester (port 0) and
//   the load/store requester (port 1). One transaction is in flight at a time:
//   IDLE (arbitrate/accept) -> ACCESS (ROM read) -> RESP (hold response until
//   consumed) -> IDLE. Word addresses >= WORDS skip the ROM and answer with
//   resp_err = 1, resp_data = 0.
// Parameters:
//   WORDS : ROM depth in 32-bit words (legal word addresses 0..WORDS-1).
// Ports:
//   clk   : clock, all state changes on the rising edge.
//   rst_n : synchronous active-low reset.
//   bus   : rom_arbiter_if.slave (both request/response channels + ROM port).
// Build option:
//   ROM_ARB_RR_EN defined   -> round-robin on simultaneous requests.
//   ROM_ARB_RR_EN undefined -> fixed priority, port 0 wins ties.
module rom_arbiter #(
  parameter int unsigned WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_arbiter_if.slave  bus
);

  localparam logic [31:0] WORDS_W = 32'(WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        owner_q;

`ifdef ROM_ARB_RR_EN
  logic        last_grant;
`endif

  logic        grant_vld;
  logic        grant_sel;
  logic [29:0] grant_addr;
  logic        in_range;
  logic        accept;
  logic        owner_ready;

  // Arbitration: a lone requester always wins; only ties consult the policy.
  always_comb begin
    grant_vld = bus.p0_req_valid | bus.p1_req_valid;
    if (bus.p0_req_valid && bus.p1_req_valid) begin
`ifdef ROM_ARB_RR_EN
      grant_sel = ~last_grant;
`else
      grant_sel = 1'b0;
`endif
    end else begin
      grant_sel = ~bus.p0_req_valid;
    end
    grant_addr = grant_sel ? bus.p1_req_addr : bus.p0_req_addr;
    in_range   = ({2'b00, grant_addr} < WORDS_W);
  end

  assign owner_ready = owner_q ? bus.p1_resp_ready : bus.p0_resp_ready;

  // Next state and all outputs.
  always_comb begin
    state_nxt         = state;
    accept            = 1'b0;
    bus.p0_req_ready  = 1'b0;
    bus.p1_req_ready  = 1'b0;
    bus.p0_resp_valid = 1'b0;
    bus.p1_resp_valid = 1'b0;
    bus.p0_resp_data  = '0;
    bus.p1_resp_data  = '0;
    bus.p0_resp_err   = 1'b0;
    bus.p1_resp_err   = 1'b0;
    bus.rom_re        = 1'b0;
    bus.rom_addr      = addr_q;

    case (state)
      IDLE: begin
        // Ready is held low while reset is asserted so nothing is accepted.
        if (rst_n && grant_vld) begin
          accept = 1'b1;
          if (grant_sel) bus.p1_req_ready = 1'b1;
          else           bus.p0_req_ready = 1'b1;
          state_nxt = in_range ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        bus.rom_re = 1'b1;
        state_nxt  = RESP;
      end
      RESP: begin
        if (owner_q) begin
          bus.p1_resp_valid = 1'b1;
          bus.p1_resp_data  = data_q;
          bus.p1_resp_err   = err_q;
        end else begin
          bus.p0_resp_valid = 1'b1;
          bus.p0_resp_data  = data_q;
          bus.p0_resp_err   = err_q;
        end
        // Completion always returns to IDLE; a new grant needs a fresh cycle.
        if (owner_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      owner_q <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= grant_addr;
        owner_q <= grant_sel;
        err_q   <= ~in_range;
        // Error responses carry zero data; the ROM is never touched.
        if (!in_range) data_q <= '0;
`ifdef ROM_ARB_RR_EN
        last_grant <= grant_sel;
`endif
      end
      // ROM output was registered on the falling edge inside ACCESS.
      if (state == ACCESS) begin
        data_q <= bus.rom_rd;
        err_q  <= 1'b0;
      end
    end
  end

  a_one_ready : assert property (@(posedge clk)
    !(bus.p0_req_ready && bus.p1_req_ready));

  a_one_resp : assert property (@(posedge clk)
    !(bus.p0_resp_valid && bus.p1_resp_valid));

  a_p0_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.p0_resp_valid && !bus.p0_resp_ready) |=>
      (bus.p0_resp_valid && $stable(bus.p0_resp_data)));

  a_p1_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.p1_resp_valid && !bus.p1_resp_ready) |=>
      (bus.p1_resp_valid && $stable(bus.p1_resp_data)));

endmodule
